// File: rtl/sorted_stream_tx.sv
// sorted_stream_tx: captures whole sorted frames into a two-slot ping-pong
// buffer and streams them out one element per beat on a valid/ready port.
module sorted_stream_tx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_valid,
  input  logic [DEPTH-1:0][WIDTH-1:0] frame_data,
  output logic                        m_valid,
  output logic [WIDTH-1:0]            m_data,
  output logic [IDXW-1:0]             m_index,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        overflow,
  output logic [7:0]                  drop_count
);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  rstSync_q;
  logic                        rstInt_n;
  logic [DEPTH-1:0][WIDTH-1:0] slot_q [2];
  logic                        wrPtr_q, wrPtr_d;
  logic                        rdPtr_q, rdPtr_d;
  logic [1:0]                  occ_q, occ_d;
  logic [IDXW-1:0]             idx_q, idx_d, idxNext;
  logic [WIDTH-1:0]            data_q, data_d;
  logic                        last_q, last_d;
  logic                        busy_q, busy_d;
  logic                        overflow_q, overflow_d;
  logic [7:0]                  dropCount_q, dropCount_d;
  logic                        handshake, lastHs, accept, drop, nextSlot;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstSync_q <= 2'b00;
    else      rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstInt_n = rstSync_q[1];

  // Frame storage; an accepted frame always lands in the write-pointer slot.
  always_ff @(posedge clk) begin
    if (accept) slot_q[wrPtr_q] <= frame_data;
  end

  // Next-state decode: acceptance, pointer/occupancy bookkeeping and the next beat.
  always_comb begin
    handshake   = (state_q == STREAM) && m_ready;
    lastHs      = handshake && (idx_q == IDXW'(DEPTH-1));
    accept      = frame_valid && ((occ_q != 2'd2) || lastHs);
    drop        = frame_valid && !accept;
    nextSlot    = ~rdPtr_q;
    idxNext     = idx_q + IDXW'(1);
    occ_d       = occ_q + {1'b0, accept} - {1'b0, lastHs};
    state_d     = (occ_d != 2'd0) ? STREAM : IDLE;
    wrPtr_d     = accept ? ~wrPtr_q : wrPtr_q;
    rdPtr_d     = lastHs ? ~rdPtr_q : rdPtr_q;
    idx_d       = idx_q;
    data_d      = data_q;
    if (lastHs) begin
      idx_d  = '0;
      data_d = (accept && (wrPtr_q == nextSlot)) ? frame_data[0] : slot_q[nextSlot][0];
    end else if (handshake) begin
      idx_d  = idxNext;
      data_d = slot_q[rdPtr_q][idxNext];
    end else if ((state_q == IDLE) && accept) begin
      idx_d  = '0;
      data_d = frame_data[0];
    end
    last_d      = (idx_d == IDXW'(DEPTH-1));
    busy_d      = (occ_d != 2'd0);
    overflow_d  = drop;
    dropCount_d = (drop && (dropCount_q != 8'hFF)) ? dropCount_q + 8'd1 : dropCount_q;
  end

  // State and output registers, cleared by the synchronised reset.
  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q     <= IDLE;
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      occ_q       <= 2'd0;
      idx_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dropCount_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      occ_q       <= occ_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      dropCount_q <= dropCount_d;
    end
  end

  assign m_valid    = (state_q == STREAM);
  assign m_data     = data_q;
  assign m_index    = idx_q;
  assign m_last     = last_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign drop_count = dropCount_q;

endmodule
